mem_wr_rr_arbiter: RTL and testbench
====================================

// Module: mem_wr_rr_arbiter
// PURPOSE
// - Next-generation write-port arbiter for the shared packet buffer. Sits between the
//   NUM_PORTS per-port memory write controllers and the single buffer SRAM write port.
// - Replaces the free-running slot rotation with a valid/ready handshake.
// - Runtime mode select: fixed TDM slots, or work-conserving round robin.
// - Optional burst lock keeps one port granted for a multi-beat packet segment.
// PARAMETERS
// - NUM_PORTS  4           : number of requesting write controllers (>=1)
// - DATA_W     BLOCK_BITS  : write-data width per beat
// - AW         ADDR_W      : buffer block-address width
// - MAX_BURST  8           : max beats a port may hold the grant under lock (>=1)
// PORTS
// - clk          in   1             : single clock domain
// - rst          in   1             : synchronous reset, active-high
// - mode_rr_i    in   1             : 0 = TDM slots, 1 = work-conserving round robin
// - req_valid_i  in   [NUM_PORTS]   : port has a write beat
// - req_last_i   in   [NUM_PORTS]   : beat is last of burst (releases lock)
// - req_addr_i   in   AW x NUM_PORTS   : per-port write address
// - req_data_i   in   DATA_W x NUM_PORTS : per-port write data
// - req_ready_o  out  [NUM_PORTS]   : one-hot grant; beat accepted when valid&ready
// - mem_we_o     out  1             : registered SRAM write enable
// - mem_addr_o   out  AW            : registered SRAM address
// - mem_wdata_o  out  DATA_W        : registered SRAM write data
// - mem_port_o   out  $clog2(NUM_PORTS) (min 1) : source port of the current mem write
// - lock_o       out  1             : burst lock currently held
// BEHAVIOUR
// - Reset (rst=1 at posedge): ptr=0, lock=0, beat_cnt=0.
//   All registered outputs are 0. req_ready_o is all-0 while rst is high.
// - req_ready_o is combinational from req_valid_i and state.
//   At most one bit is set, and only for a port with req_valid_i=1.
// - Accepted beat (valid&ready on port p) appears on mem_* the next cycle:
//   - latency = 1;
//   - mem_we_o=1, mem_port_o=p.
//   - mem_we_o=0 in any cycle after no acceptance.
// - TDM (mode_rr_i=0):
//   - ptr increments every cycle, wrapping NUM_PORTS-1 -> 0.
//   - Only port ptr may be granted.
//   - Lock is ignored and forced to 0.
// - RR (mode_rr_i=1), unlocked:
//   - grant the first valid port scanning ptr, ptr+1, ... (mod NUM_PORTS).
//   - On acceptance from p: ptr <= (p+1) mod NUM_PORTS. No acceptance -> ptr holds.
// - RR locked:
//   - entered when a beat from p is accepted with req_last_i[p]=0.
//   - lock_port=p; beat_cnt counts accepted beats including the first.
//   - While locked, only lock_port is eligible. Other ports see ready=0 even if it idles.
//   - Lock releases after the beat with req_last_i=1, or when beat_cnt reaches MAX_BURST.
//     On release, ptr <= lock_port+1.
//   - A locked port dropping valid does not release the lock.
// - MAX_BURST=1: lock never asserts; arbitration is pure per-beat RR.
// - mode_rr_i change: sampled per cycle. A switch to TDM clears lock and beat_cnt
//   immediately. A switch to RR starts from the current ptr.
// - Reset mid-burst: lock cleared and the in-flight registered beat discarded
//   (mem_we_o=0 the next cycle).
// - NUM_PORTS=1: ptr is constant 0 and mem_port_o=0.
// - No beat is ever dropped or duplicated: each valid&ready pair yields exactly one mem write.
// STRUCTURE
// - mem_pkg: ADDR_W, BLOCK_BITS; add typedef port_idx_t = logic [$clog2(NUM_PORTS)-1:0];
//   add localparam MAX_BURST_DEFAULT = 8.
// - Sub-module rr_pick #(N): combinational rotate-priority picker.
//   Inputs: req vector, start ptr. Outputs: one-hot grant, index, any.
//   Used for the RR scan; TDM bypasses it.
// - Top holds ptr, lock/lock_port/beat_cnt FSM (IDLE/LOCKED), output register stage.
// TESTING
// - TDM, all 4 ports valid constantly -> ready rotates 0,1,2,3,0; each mem write
//   appears 1 cycle later with the matching mem_port_o and addr.
// - RR, only port 2 valid for 10 cycles -> 10 consecutive grants to 2, ptr ends at 3,
//   mem_we_o=1 for 10 cycles.
// - RR, ports 0 and 3 valid, ptr=1 -> grant order 3,0,3,0; ports 1 and 2 never get ready.
// - RR, MAX_BURST=4, port 1 sends 6 beats with last on beat 6, port 0 valid throughout:
//   - beats 1-4 go to port 1;
//   - then port 0 gets one beat;
//   - then port 1 sends beats 5-6.
// - Lock held, port 1 drops valid 3 cycles, port 2 valid -> port 2 stays ungranted and
//   lock_o stays 1; port 1 resumes with last=1 -> lock releases and port 2 is granted next.
// - rst asserted mid-burst -> next cycle mem_we_o=0, lock_o=0, req_ready_o=0.
//   After release, RR arbitration restarts from port 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared packet-buffer constants and types used by the write-port arbiter.
package mem_pkg;

  localparam int ADDR_W            = 16;
  localparam int BLOCK_BITS        = 32;
  localparam int NUM_PORTS_DEFAULT = 4;
  localparam int MAX_BURST_DEFAULT = 8;

  typedef logic [$clog2(NUM_PORTS_DEFAULT)-1:0] port_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_e;

endpackage

// File: rtl/mem_wr_rr_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first set request scanning from start_i upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int          cand;
    logic [IW-1:0] cidx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(start_i) + k) % N;
      cidx = IW'(cand);
      if (!any_o && req_i[cidx]) begin
        any_o       = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_wr_rr_arbiter.sv
// Write-port arbiter for the shared packet buffer: TDM or work-conserving RR with
// optional burst lock, feeding a registered SRAM write port.
module mem_wr_rr_arbiter
  import mem_pkg::*;
#(
  parameter int  NUM_PORTS = NUM_PORTS_DEFAULT,
  parameter int  DATA_W    = BLOCK_BITS,
  parameter int  AW        = ADDR_W,
  parameter int  MAX_BURST = MAX_BURST_DEFAULT,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode_rr_i,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  input  logic [NUM_PORTS-1:0]             req_last_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]     req_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  output logic                             mem_we_o,
  output logic [AW-1:0]                    mem_addr_o,
  output logic [DATA_W-1:0]                mem_wdata_o,
  output logic [PW-1:0]                    mem_port_o,
  output logic                             lock_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  lock_state_e          state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        lock_port_q, lock_port_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [NUM_PORTS-1:0] ready;
  logic [PW-1:0]        acc_idx;
  logic                 accept;

  logic                 mem_we_q;
  logic [AW-1:0]        mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [PW-1:0]        mem_port_q;

  function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] i);
    return (i == PW'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_PORTS), .IW(PW)) u_pick (
    .req_i   (req_valid_i),
    .start_i (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant selection: TDM slot owner, locked port, or RR scan from ptr.
  always_comb begin
    ready   = '0;
    acc_idx = ptr_q;
    accept  = 1'b0;
    if (!rst) begin
      if (!mode_rr_i) begin
        ready[ptr_q] = req_valid_i[ptr_q];
        accept       = req_valid_i[ptr_q];
      end else if (state_q == ST_LOCKED) begin
        ready[lock_port_q] = req_valid_i[lock_port_q];
        acc_idx            = lock_port_q;
        accept             = req_valid_i[lock_port_q];
      end else begin
        ready   = pick_gnt;
        acc_idx = pick_idx;
        accept  = pick_any;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_port_d = lock_port_q;
    cnt_d       = cnt_q;
    if (!mode_rr_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ptr_d   = inc_idx(ptr_q);
    end else if (accept) begin
      if (state_q == ST_LOCKED) begin
        // The beat that brings the count to MAX_BURST ends the lock like a last beat.
        if (req_last_i[acc_idx] || cnt_q == CW'(MAX_BURST - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ptr_d   = inc_idx(lock_port_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ptr_d = inc_idx(acc_idx);
        if (!req_last_i[acc_idx] && MAX_BURST > 1) begin
          state_d     = ST_LOCKED;
          lock_port_d = acc_idx;
          cnt_d       = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_port_q <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_port_q <= lock_port_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= accept;
      if (accept) begin
        mem_addr_q  <= req_addr_i[acc_idx];
        mem_wdata_q <= req_data_i[acc_idx];
        mem_port_q  <= acc_idx;
      end
    end
  end

  assign req_ready_o = ready;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_port_o  = mem_port_q;
  assign lock_o      = (state_q == ST_LOCKED) && mode_rr_i;

endmodule

// File: tb/tb_mem_wr_rr_arbiter.sv
// Scoreboard bench for mem_wr_rr_arbiter: directed scenarios then random traffic
// against a queue-based arbitration model.
module tb_mem_wr_rr_arbiter;
  import mem_pkg::*;

  localparam int N   = 4;
  localparam int MB  = 4;
  localparam int DW  = BLOCK_BITS;
  localparam int AWL = ADDR_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode_rr;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_last;
  logic [N-1:0][AWL-1:0]   req_addr;
  logic [N-1:0][DW-1:0]    req_data;
  logic [N-1:0]            ready;
  logic                    mem_we;
  logic [AWL-1:0]          mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [1:0]              mem_port;
  logic                    lock;

  always #5 clk = ~clk;

  mem_wr_rr_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .AW(AWL), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_rr_i   (mode_rr),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_port_o  (mem_port),
    .lock_o      (lock)
  );

  typedef struct {
    int             port;
    logic [AWL-1:0] addr;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: slot/scan pointer, lock flag, lock owner, beats in current lock.
  int m_ptr  = 0;
  int m_lock = 0;
  int m_lp   = 0;
  int m_cnt  = 0;
  int last_g = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit m, input logic [N-1:0] v, input logic [N-1:0] l);
    int           g;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    @(negedge clk);
    rst       = r;
    mode_rr   = m;
    req_valid = v;
    req_last  = l;
    for (int p = 0; p < N; p++) begin
      req_addr[p] = AWL'($urandom);
      req_data[p] = DW'($urandom);
    end
    #1;
    g = -1;
    if (!r) begin
      if (!m) begin
        if (v[m_ptr]) g = m_ptr;
      end else if (m_lock != 0) begin
        if (v[m_lp]) g = m_lp;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", ready, exp_rdy);
    chk("lock_o", lock, (m_lock != 0) && m);
    last_g = g;
    if (g >= 0) begin
      e.port = g;
      e.addr = req_addr[g];
      e.data = req_data[g];
      sb.push_back(e);
    end
    if (r) begin
      m_ptr = 0; m_lock = 0; m_cnt = 0;
    end else if (!m) begin
      m_ptr = (m_ptr + 1) % N; m_lock = 0; m_cnt = 0;
    end else if (g >= 0) begin
      if (m_lock != 0) begin
        m_cnt++;
        if (l[g] || m_cnt >= MB) begin
          m_lock = 0; m_cnt = 0; m_ptr = (m_lp + 1) % N;
        end
      end else begin
        m_ptr = (g + 1) % N;
        if (!l[g] && MB > 1) begin
          m_lock = 1; m_lp = g; m_cnt = 1;
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mem_we) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: mem_we_o=1 from port %0d, expected no write", mem_port);
        end else begin
          e = sb.pop_front();
          chk("mem_port", mem_port, e.port);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.data);
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL missing_write: mem_we_o=0, expected write from port %0d", e.port);
      end
    end
  end

  initial begin : stim
    int bseq[7];
    int p1;
    int nrr;
    bit rm;
    bseq      = '{1, 1, 1, 1, 0, 1, 1};
    rst       = 1'b1;
    mode_rr   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;

    repeat (3) drive(1'b1, 1'b0, 4'hF, 4'h0);
    @(posedge clk); #1;
    chk("reset_mem_we", mem_we, 0);
    chk("reset_lock", lock, 0);
    chk("reset_mem_port", mem_port, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 4'hF, 4'($urandom));
      chk("tdm_order", last_g, i % N);
    end

    nrr = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'b0100, 4'hF);
      if (last_g == 2) nrr++;
    end
    chk("rr_port2_grants", nrr, 10);

    drive(1'b0, 1'b1, 4'b0001, 4'hF);
    chk("rr_ptr_after_port2", last_g, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'b1001, 4'hF);
      chk("rr_03_order", last_g, (i % 2 == 0) ? 3 : 0);
    end

    drive(1'b0, 1'b1, 4'b0001, 4'hF);
    p1 = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 4'b0011, {2'b00, (p1 == 5), 1'b1});
      chk("burst_order", last_g, bseq[i]);
      if (last_g == 1) p1++;
    end

    drive(1'b0, 1'b1, 4'b0010, 4'h0);
    chk("lock_take", last_g, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'b0100, 4'h0);
      chk("lock_idle_blocks", last_g, -1);
    end
    drive(1'b0, 1'b1, 4'b0110, 4'b0010);
    chk("lock_resume", last_g, 1);
    drive(1'b0, 1'b1, 4'b0100, 4'hF);
    chk("after_release", last_g, 2);

    drive(1'b0, 1'b1, 4'b0010, 4'h0);
    drive(1'b0, 1'b1, 4'b0010, 4'h0);
    drive(1'b1, 1'b1, 4'hF, 4'h0);
    @(posedge clk); #1;
    chk("midburst_rst_we", mem_we, 0);
    chk("midburst_rst_lock", lock, 0);
    drive(1'b0, 1'b1, 4'hF, 4'hF);
    chk("restart_port0", last_g, 0);

    rm = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      drive(($urandom_range(0, 99) == 0), rm, 4'($urandom), 4'($urandom));
    end

    repeat (2) drive(1'b0, 1'b1, 4'h0, 4'h0);
    @(posedge clk); #3;
    chk("scoreboard_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
